// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory (dmem_sim) between the core load/store
// unit (port 0) and a debug/DMA requester (port 1). At most one access is
// granted per cycle. The grant is combinational, and the access commits at the
// posedge that ends the grant cycle. dmem reads have one cycle of latency. The
// arbiter remembers which port issued the read in flight and returns out_word
// to that port with a valid strobe in the next cycle.
//
// Arbitration:
//   default               : fixed priority to port 0. Port 1 wins a contended
//                           cycle once it has been denied MAX_WAIT consecutive
//                           cycles (starvation guard).
//   DMEM_ARB_RR_EN defined: round robin. rr_ptr names the preferred port on
//                           contention and moves to the loser after every
//                           contended grant. The starvation counter is absent.
//
// Parameters:
//   WORD_WIDTH  data word width (matches dmem)
//   ADDR_WIDTH  byte address width (matches dmem)
//   MAX_WAIT    denied cycles of port 1 before it is force-granted (1..15)
//   WAIT_WIDTH  starvation counter width; must hold MAX_WAIT
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   in_pX_req/we/addr/wdata   port X request, write(1)/read(0), address, data
//   out_pX_gnt                port X granted this cycle (combinational)
//   out_pX_rvalid             port X read data valid (from registered state)
//   out_pX_rdata              port X read data, 0 when rvalid is low
//   out_mem_addr_rd/_wr       dmem read / write address (winner's address)
//   out_mem_word              dmem write data (winner's wdata)
//   out_mem_write_en          dmem write enable
//   in_mem_word               dmem read data (one cycle after the address)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned WAIT_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  in_p0_req,
  input  logic                  in_p0_we,
  input  logic [ADDR_WIDTH-1:0] in_p0_addr,
  input  logic [WORD_WIDTH-1:0] in_p0_wdata,
  output logic                  out_p0_gnt,
  output logic                  out_p0_rvalid,
  output logic [WORD_WIDTH-1:0] out_p0_rdata,

  input  logic                  in_p1_req,
  input  logic                  in_p1_we,
  input  logic [ADDR_WIDTH-1:0] in_p1_addr,
  input  logic [WORD_WIDTH-1:0] in_p1_wdata,
  output logic                  out_p1_gnt,
  output logic                  out_p1_rvalid,
  output logic [WORD_WIDTH-1:0] out_p1_rdata,

  output logic [ADDR_WIDTH-1:0] out_mem_addr_rd,
  output logic [ADDR_WIDTH-1:0] out_mem_addr_wr,
  output logic [WORD_WIDTH-1:0] out_mem_word,
  output logic                  out_mem_write_en,
  input  logic [WORD_WIDTH-1:0] in_mem_word
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  logic  gnt0;
  logic  gnt1;
  logic  contended;
  logic  rd_grant;
  logic  rd_pend;
  port_e rd_sel;

  assign contended = in_p0_req & in_p1_req;

`ifdef DMEM_ARB_RR_EN
  port_e rr_ptr;
`else
  localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MAX_WAIT);
  logic [WAIT_WIDTH-1:0] wait_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Grant decision. Both grants are forced low during reset, so a request seen
  // in a reset cycle can neither start a read nor commit a write.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (contended) begin
`ifdef DMEM_ARB_RR_EN
        if (rr_ptr == PORT1) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
`else
        if (wait_cnt == WAIT_LIMIT) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
`endif
      end else begin
        gnt0 = in_p0_req;
        gnt1 = in_p1_req;
      end
    end
  end

  assign out_p0_gnt = gnt0;
  assign out_p1_gnt = gnt1;

  // ---------------------------------------------------------------------------
  // Memory drive: the winner's request goes straight to dmem. With no winner
  // every memory input is parked at zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_mem_addr_rd  = '0;
    out_mem_addr_wr  = '0;
    out_mem_word     = '0;
    out_mem_write_en = 1'b0;
    if (gnt0) begin
      out_mem_addr_rd  = in_p0_addr;
      out_mem_addr_wr  = in_p0_addr;
      out_mem_word     = in_p0_wdata;
      out_mem_write_en = in_p0_we;
    end else if (gnt1) begin
      out_mem_addr_rd  = in_p1_addr;
      out_mem_addr_wr  = in_p1_addr;
      out_mem_word     = in_p1_wdata;
      out_mem_write_en = in_p1_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Read tracking. rd_sel changes only on a granted read. It is only
  // meaningful while rd_pend is high.
  // ---------------------------------------------------------------------------
  assign rd_grant = (gnt0 & ~in_p0_we) | (gnt1 & ~in_p1_we);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_sel  <= PORT0;
    end else begin
      rd_pend <= rd_grant;
      if (gnt1 && !in_p1_we) begin
        rd_sel <= PORT1;
      end else if (gnt0 && !in_p0_we) begin
        rd_sel <= PORT0;
      end
    end
  end

  assign out_p0_rvalid = rd_pend & (rd_sel == PORT0);
  assign out_p1_rvalid = rd_pend & (rd_sel == PORT1);
  assign out_p0_rdata  = out_p0_rvalid ? in_mem_word : '0;
  assign out_p1_rdata  = out_p1_rvalid ? in_mem_word : '0;

`ifdef DMEM_ARB_RR_EN
  // ---------------------------------------------------------------------------
  // Round-robin pointer: after a contended grant the loser becomes preferred.
  // Uncontested grants leave the preference alone.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= PORT0;
    end else if (contended) begin
      rr_ptr <= gnt0 ? PORT1 : PORT0;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive denied cycles of port 1 and
  // saturates at the limit. The counter clears as soon as port 1 is served or
  // drops its request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (in_p1_req && !gnt1) begin
      if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A behavioural dmem (1-cycle registered
// read) sits behind the arbiter. A reference model kept as plain counters and
// a shadow memory predicts grants, memory drive and read returns each cycle.
// Define DMEM_ARB_RR_EN for both the bench and the RTL to check round-robin
// mode.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [11:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [11:0] mem_addr_rd, mem_addr_wr;
  logic [15:0] mem_word, mem_q;
  logic        mem_we;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .WORD_WIDTH(16),
    .ADDR_WIDTH(12),
    .MAX_WAIT  (MAX_WAIT),
    .WAIT_WIDTH(4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_p0_req       (p0_req),
    .in_p0_we        (p0_we),
    .in_p0_addr      (p0_addr),
    .in_p0_wdata     (p0_wdata),
    .out_p0_gnt      (p0_gnt),
    .out_p0_rvalid   (p0_rvalid),
    .out_p0_rdata    (p0_rdata),
    .in_p1_req       (p1_req),
    .in_p1_we        (p1_we),
    .in_p1_addr      (p1_addr),
    .in_p1_wdata     (p1_wdata),
    .out_p1_gnt      (p1_gnt),
    .out_p1_rvalid   (p1_rvalid),
    .out_p1_rdata    (p1_rdata),
    .out_mem_addr_rd (mem_addr_rd),
    .out_mem_addr_wr (mem_addr_wr),
    .out_mem_word    (mem_word),
    .out_mem_write_en(mem_we),
    .in_mem_word     (mem_q)
  );

  // Behavioural dmem: registered read, write at posedge.
  logic [15:0] mem [0:4095];
  always @(posedge clock) begin
    if (mem_we === 1'b1) mem[mem_addr_wr] <= mem_word;
    mem_q <= mem[mem_addr_rd];
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [15:0] ref_mem [0:4095];
  int          m_deny;   // consecutive cycles port 1 was refused
  int          m_rr;     // preferred port on contention (round robin)
  bit          m_pend;   // a read was granted last cycle
  int          m_pport;
  logic [15:0] m_pdata;

  bit          e_g0, e_g1, e_we, e_rv0, e_rv1;
  logic [11:0] e_addr;
  logic [15:0] e_word, e_rd0, e_rd1;

  function automatic logic [15:0] pre(input int a);
    return 16'(a * 7 + 'h5A00);
  endfunction

  function void predict();
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (reset !== 1'b1) begin
      if (p0_req && p1_req) begin
        if (RR_MODE) begin
          if (m_rr == 1) e_g1 = 1'b1; else e_g0 = 1'b1;
        end else begin
          if (m_deny >= MAX_WAIT) e_g1 = 1'b1; else e_g0 = 1'b1;
        end
      end else begin
        e_g0 = p0_req;
        e_g1 = p1_req;
      end
    end
    e_we = 1'b0; e_addr = '0; e_word = '0;
    if (e_g0) begin
      e_we = p0_we; e_addr = p0_addr; e_word = p0_wdata;
    end else if (e_g1) begin
      e_we = p1_we; e_addr = p1_addr; e_word = p1_wdata;
    end
    e_rv0 = m_pend && (m_pport == 0);
    e_rv1 = m_pend && (m_pport == 1);
    e_rd0 = e_rv0 ? m_pdata : 16'h0;
    e_rd1 = e_rv1 ? m_pdata : 16'h0;
  endfunction

  function void commit();
    if (reset === 1'b1) begin
      m_deny = 0; m_rr = 0; m_pend = 0;
      return;
    end
    m_pend = 0;
    if (e_g0 || e_g1) begin
      if (!e_we) begin
        m_pend  = 1;
        m_pport = e_g1 ? 1 : 0;
        m_pdata = ref_mem[e_addr];
      end else begin
        ref_mem[e_addr] = e_word;
      end
      if (p0_req && p1_req) m_rr = e_g1 ? 0 : 1;
    end
    if (p1_req && !e_g1) m_deny = (m_deny + 1 > MAX_WAIT) ? MAX_WAIT : m_deny + 1;
    else m_deny = 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle sequencing: inputs change 1 ns after posedge, outputs are sampled
  // at negedge, the model advances at posedge.
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic settle();
    @(negedge clock);
    predict();
  endtask

  task automatic advance();
    @(posedge clock);
    commit();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p0_req = 1'($urandom); p0_we = 1'($urandom); p0_addr = 12'($urandom);
      p1_req = 1'($urandom); p1_we = 1'($urandom); p1_addr = 12'($urandom);
      settle();
      nchecks++;
      if ({p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid} !== 5'b0) begin
        nerr++;
        $display("FAIL reset_ctrl got %b want 00000", {p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid});
      end
      nchecks++;
      if ({mem_addr_rd, mem_addr_wr, mem_word, p0_rdata, p1_rdata} !== '0) begin
        nerr++;
        $display("FAIL reset_data got %h %h %h %h %h want all 0",
                 mem_addr_rd, mem_addr_wr, mem_word, p0_rdata, p1_rdata);
      end
      advance();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      settle();
      nchecks++;
      if ({p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid} !== 5'b0 ||
          {mem_addr_rd, mem_addr_wr, mem_word} !== '0) begin
        nerr++;
        $display("FAIL idle got ctrl=%b ard=%h awr=%h word=%h want all 0",
                 {p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid}, mem_addr_rd, mem_addr_wr, mem_word);
      end
      advance();
    end
  endtask

  task automatic test_write_then_read();
    idle_inputs();
    p0_req = 1; p0_we = 1; p0_addr = 12'h010; p0_wdata = 16'hBEEF;
    settle();
    nchecks++;
    if ({p0_gnt, p1_gnt, mem_we} !== 3'b101 || mem_addr_wr !== 12'h010 || mem_word !== 16'hBEEF) begin
      nerr++;
      $display("FAIL wr_cycle got gnt=%b%b we=%b addr=%h word=%h want 10 1 010 beef",
               p0_gnt, p1_gnt, mem_we, mem_addr_wr, mem_word);
    end
    advance();
    p0_we = 0; p0_wdata = '0;
    settle();
    nchecks++;
    if ({p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid} !== 5'b10000 || mem_addr_rd !== 12'h010) begin
      nerr++;
      $display("FAIL rd_cycle got ctrl=%b addr=%h want 10000 010",
               {p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid}, mem_addr_rd);
    end
    advance();
    idle_inputs();
    settle();
    nchecks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 16'hBEEF || p1_rvalid !== 1'b0 || p1_rdata !== 16'h0) begin
      nerr++;
      $display("FAIL raw_return got p0 %b/%h p1 %b/%h want 1/beef 0/0000",
               p0_rvalid, p0_rdata, p1_rvalid, p1_rdata);
    end
    advance();
  endtask

  // Continuous contention: reads in fixed mode, writes in round-robin mode.
  task automatic test_contention();
    bit want1;
    for (int i = 0; i < 10; i++) begin
      p0_req = 1; p0_we = RR_MODE; p0_addr = 12'(12'h200 + 2 * i); p0_wdata = 16'($urandom);
      p1_req = 1; p1_we = RR_MODE; p1_addr = 12'(12'h300 + 2 * i); p1_wdata = 16'($urandom);
      settle();
      want1 = RR_MODE ? (i % 2 == 1) : (i % 5 == 4);
      nchecks++;
      if ({p0_gnt, p1_gnt} !== {~want1, want1} || {e_g0, e_g1} !== {~want1, want1}) begin
        nerr++;
        $display("FAIL contention[%0d] got gnt=%b%b want %b%b", i, p0_gnt, p1_gnt, ~want1, want1);
      end
      nchecks++;
      if ({p0_rvalid, p1_rvalid} !== {e_rv0, e_rv1} || p0_rdata !== e_rd0 || p1_rdata !== e_rd1) begin
        nerr++;
        $display("FAIL contention_rd[%0d] got %b%b %h %h want %b%b %h %h", i,
                 p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, e_rv0, e_rv1, e_rd0, e_rd1);
      end
      advance();
    end
    idle_inputs();
    settle();
    nchecks++;
    if ({p0_rvalid, p1_rvalid} !== {e_rv0, e_rv1} || p0_rdata !== e_rd0 || p1_rdata !== e_rd1) begin
      nerr++;
      $display("FAIL contention_tail got %b%b %h %h want %b%b %h %h",
               p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, e_rv0, e_rv1, e_rd0, e_rd1);
    end
    advance();
  endtask

  task automatic test_alternating();
    idle_inputs();
    p1_req = 1; p1_addr = 12'h020;
    settle();
    nchecks++;
    if ({p0_gnt, p1_gnt} !== 2'b01 || mem_addr_rd !== 12'h020 || mem_we !== 1'b0) begin
      nerr++;
      $display("FAIL alt_c0 got gnt=%b%b addr=%h we=%b want 01 020 0", p0_gnt, p1_gnt, mem_addr_rd, mem_we);
    end
    advance();
    idle_inputs();
    p0_req = 1; p0_addr = 12'h022;
    settle();
    nchecks++;
    if ({p0_gnt, p1_gnt} !== 2'b10 || p1_rvalid !== 1'b1 || p1_rdata !== pre('h20) || p0_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL alt_c1 got gnt=%b%b p1 %b/%h p0v=%b want 10 1/%h 0",
               p0_gnt, p1_gnt, p1_rvalid, p1_rdata, p0_rvalid, pre('h20));
    end
    advance();
    idle_inputs();
    settle();
    nchecks++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== pre('h22) || p1_rvalid !== 1'b0 || p1_rdata !== 16'h0) begin
      nerr++;
      $display("FAIL alt_c2 got p0 %b/%h p1 %b/%h want 1/%h 0/0000",
               p0_rvalid, p0_rdata, p1_rvalid, p1_rdata, pre('h22));
    end
    advance();
  endtask

  task automatic test_reset_mid();
    bit want1;
    // Build up contention history with writes so no read is in flight.
    for (int i = 0; i < 2; i++) begin
      p0_req = 1; p0_we = 1; p0_addr = 12'h280; p0_wdata = 16'($urandom);
      p1_req = 1; p1_we = 1; p1_addr = 12'h380; p1_wdata = 16'($urandom);
      settle();
      advance();
    end
    reset = 1'b1;
    p1_req = 1; p1_we = 0; p1_addr = 12'h020;
    p0_req = 1; p0_we = 1; p0_addr = 12'h022; p0_wdata = 16'hDEAD;
    settle();
    nchecks++;
    if ({p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid} !== 5'b0 ||
        {mem_addr_rd, mem_addr_wr, mem_word, p0_rdata, p1_rdata} !== '0) begin
      nerr++;
      $display("FAIL mid_reset got ctrl=%b ard=%h word=%h want all 0",
               {p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid}, mem_addr_rd, mem_word);
    end
    advance();
    reset = 1'b0;
    idle_inputs();
    settle();
    nchecks++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00 || {p0_rdata, p1_rdata} !== 32'h0) begin
      nerr++;
      $display("FAIL dropped_read got rv=%b%b rd=%h %h want 00 0 0", p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
    end
    advance();
    // Starvation/priority history must restart from zero after reset.
    for (int i = 0; i < 5; i++) begin
      p0_req = 1; p0_we = 0; p0_addr = 12'h022;
      p1_req = 1; p1_we = 0; p1_addr = 12'h020;
      settle();
      want1 = RR_MODE ? (i % 2 == 1) : (i % 5 == 4);
      nchecks++;
      if ({p0_gnt, p1_gnt} !== {~want1, want1}) begin
        nerr++;
        $display("FAIL post_reset_arb[%0d] got %b%b want %b%b", i, p0_gnt, p1_gnt, ~want1, want1);
      end
      if (i == 1) begin
        nchecks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== pre('h22)) begin
          nerr++;
          $display("FAIL suppressed_write got %b/%h want 1/%h", p0_rvalid, p0_rdata, pre('h22));
        end
      end
      advance();
    end
    idle_inputs();
    settle();
    advance();
  endtask

  task automatic test_random();
    bit h0 = 0, h1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!h0) begin
        h0 = ($urandom_range(0, 9) < 6);
        p0_we = 1'($urandom); p0_addr = 12'(12'h100 + 2 * $urandom_range(0, 7)); p0_wdata = 16'($urandom);
      end
      if (!h1) begin
        h1 = ($urandom_range(0, 9) < 6);
        p1_we = 1'($urandom); p1_addr = 12'(12'h100 + 2 * $urandom_range(0, 7)); p1_wdata = 16'($urandom);
      end
      p0_req = h0; p1_req = h1;
      settle();
      nchecks++;
      if ({p0_gnt, p1_gnt, mem_we} !== {e_g0, e_g1, e_we} || (p0_gnt && p1_gnt)) begin
        nerr++;
        $display("FAIL rnd_gnt[%0d] got %b%b%b want %b%b%b", i, p0_gnt, p1_gnt, mem_we, e_g0, e_g1, e_we);
      end
      nchecks++;
      if (mem_addr_rd !== e_addr || mem_addr_wr !== e_addr || mem_word !== e_word) begin
        nerr++;
        $display("FAIL rnd_drive[%0d] got %h %h %h want %h %h %h", i,
                 mem_addr_rd, mem_addr_wr, mem_word, e_addr, e_addr, e_word);
      end
      nchecks++;
      if ({p0_rvalid, p1_rvalid} !== {e_rv0, e_rv1} || p0_rdata !== e_rd0 || p1_rdata !== e_rd1) begin
        nerr++;
        $display("FAIL rnd_rd[%0d] got %b%b %h %h want %b%b %h %h", i,
                 p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, e_rv0, e_rv1, e_rd0, e_rd1);
      end
      if (e_g0) h0 = 0;
      if (e_g1) h1 = 0;
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem[a]     = pre(a);
      ref_mem[a] = pre(a);
    end
    m_deny = 0; m_rr = 0; m_pend = 0; m_pport = 0; m_pdata = '0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_idle();
    test_write_then_read();
    test_contention();
    test_alternating();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
